seven_seg_scanner: RTL and testbench

- Time-multiplexed driver for the existing 8-digit seven-segment decoder.
- Holds a 32-bit hex display value plus per-digit decimal-point and enable masks. Scans one digit per refresh period.
- Drives the decoder's num, sel and DP_IN inputs, plus a blank flag that the top level ORs into the anodes.
- New display data arrives over a valid/ready load port. It is committed only at a frame boundary, so the display never tears.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_scanner_if.sv | 13 +
 rtl/refresh_prescaler.sv | 37 +++
 rtl/seven_seg_scanner.sv | 133 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
// The downstream decoder takes its num and sel inputs with reversed bit order.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    function automatic digit_idx_t bitrev3(input digit_idx_t v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic nibble_t bitrev4(input nibble_t v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Valid/ready load port carrying a full display frame: value, decimal points, enables.
interface seven_seg_scanner_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_value;
    logic [7:0]  load_dp;
    logic [7:0]  load_en;

    modport master (output load_valid, output load_value, output load_dp,
                    output load_en, input load_ready);
    modport slave  (input load_valid, input load_value, input load_dp,
                    input load_en, output load_ready);
endinterface

// File: rtl/refresh_prescaler.sv
// Free-running divider: pulses tick once every REFRESH_DIV clk cycles.
module refresh_prescaler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned PRESC_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [PRESC_W-1:0] LAST_COUNT = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // Wrap the count on the terminal value and flag it as the tick.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (cnt_q == LAST_COUNT) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            tick  = 1'b0;
            cnt_d = cnt_q + PRESC_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit scanner; new frames are shadowed and committed
// only when the scan wraps from digit 7 to digit 0, so the display never tears.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned PRESC_W     = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  load,
    output logic [3:0]          num,
    output logic [2:0]          sel,
    output logic                dp,
    output logic                blank
);
    logic                  tick_s;
    logic                  commit_s;
    logic                  accept_s;

    digit_idx_t            idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [31:0]           shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic [31:0]           active_value_q, active_value_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0] active_en_q, active_en_d;
    nibble_t               num_q, num_d;
    digit_idx_t            sel_q, sel_d;
    logic                  dp_q, dp_d;
    logic                  blank_q, blank_d;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .PRESC_W     (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // Accept and commit can never coincide: one needs pending low, the other high.
    always_comb begin
        accept_s       = load.load_valid && !pending_q;
        commit_s       = tick_s && (idx_q == 3'd7) && pending_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_en_d    = shadow_en_q;
        active_value_d = active_value_q;
        active_dp_d    = active_dp_q;
        active_en_d    = active_en_q;

        if (tick_s) begin
            idx_d = idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end

        if (accept_s) begin
            pending_d      = 1'b1;
            shadow_value_d = load.load_value;
            shadow_dp_d    = load.load_dp;
            shadow_en_d    = load.load_en;
        end else if (commit_s) begin
            pending_d      = 1'b0;
            active_value_d = shadow_value_q;
            active_dp_d    = shadow_dp_q;
            active_en_d    = shadow_en_q;
        end else begin
            pending_d = pending_q;
        end
    end

    // Outputs use next-idx and next-active values so they track the digit being entered.
    always_comb begin
        num_d   = num_q;
        sel_d   = sel_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (tick_s) begin
            num_d   = bitrev4(active_value_d[{idx_d, 2'b00} +: 4]);
            sel_d   = bitrev3(idx_d);
            dp_d    = ~active_dp_d[idx_d];
            blank_d = ~active_en_d[idx_d];
        end else begin
            num_d   = num_q;
            sel_d   = sel_q;
            dp_d    = dp_q;
            blank_d = blank_q;
        end
        load.load_ready = ~pending_q;
    end

    // Scanner state, shadow/active frames and registered decoder outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= 3'd0;
            pending_q      <= 1'b0;
            shadow_value_q <= 32'd0;
            shadow_dp_q    <= 8'h00;
            shadow_en_q    <= 8'h00;
            active_value_q <= 32'd0;
            active_dp_q    <= 8'h00;
            active_en_q    <= 8'hFF;
            num_q          <= 4'b0000;
            sel_q          <= 3'b000;
            dp_q           <= 1'b1;
            blank_q        <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            active_value_q <= active_value_d;
            active_dp_q    <= active_dp_d;
            active_en_q    <= active_en_d;
            num_q          <= num_d;
            sel_q          <= sel_d;
            dp_q           <= dp_d;
            blank_q        <= blank_d;
        end
    end

    assign num   = num_q;
    assign sel   = sel_q;
    assign dp    = dp_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV = 4 (one frame = 32 cycles).
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num;
    logic [2:0] sel;
    logic       dp;
    logic       blank;

    always #5 clk = ~clk;

    seven_seg_scanner_if ld ();

    seven_seg_scanner #(
        .REFRESH_DIV (4),
        .PRESC_W     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld.slave),
        .num   (num),
        .sel   (sel),
        .dp    (dp),
        .blank (blank)
    );

    typedef struct packed {
        logic [3:0] num;
        logic [2:0] sel;
        logic       dp;
        logic       blank;
    } exp_t;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
    } load_t;

    // Scenario 0 = reset contents; 1..3 = loaded frames. Expected per digit index.
    exp_t  tbl [4][8];
    load_t ldv [4];

    logic [2:0] sel_of [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    logic [3:0] num_s0 [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] num_s1 [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] num_s2 [8] = '{4'b1111, 4'b0111, 4'b1011, 4'b0011, 4'b1101, 4'b0101, 4'b1001, 4'b0001};
    logic [3:0] num_s3 [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    // Bit i = expected dp / blank output while digit i is scanned.
    logic [7:0] edp   [4] = '{8'b1111_1111, 8'b1111_1110, 8'b0111_1111, 8'b0000_0000};
    logic [7:0] eblnk [4] = '{8'b0000_0000, 8'b0000_0000, 8'b0101_1010, 8'b1111_1111};

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    int shown    = 0;
    int pend_scn = 0;
    bit pend     = 1'b0;
    bit drv_valid = 1'b0;
    int drv_scn  = 0;
    int guard;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = tbl[shown][(n / 4) % 8];
        chk("num",        {28'd0, num},   {28'd0, e.num});
        chk("sel",        {29'd0, sel},   {29'd0, e.sel});
        chk("dp",         {31'd0, dp},    {31'd0, e.dp});
        chk("blank",      {31'd0, blank}, {31'd0, e.blank});
        chk("load_ready", {31'd0, ld.load_ready}, {31'd0, ~pend});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_num"},   {28'd0, num},   32'd0);
        chk({tag, "_sel"},   {29'd0, sel},   32'd0);
        chk({tag, "_dp"},    {31'd0, dp},    32'd1);
        chk({tag, "_blank"}, {31'd0, blank}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ld.load_ready}, 32'd1);
    endtask

    // One clock: advance the frame-timing model, then sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        n++;
        if (pend && (n % 32 == 0)) begin
            shown = pend_scn;
            pend  = 1'b0;
        end else if (drv_valid && !pend) begin
            pend_scn = drv_scn;
            pend     = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic offer(input int s);
        drv_valid     = 1'b1;
        drv_scn       = s;
        ld.load_valid = 1'b1;
        ld.load_value = ldv[s].value;
        ld.load_dp    = ldv[s].dp;
        ld.load_en    = ldv[s].en;
    endtask

    task automatic withdraw();
        drv_valid     = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_value = $urandom;
        ld.load_dp    = 8'($urandom);
        ld.load_en    = 8'($urandom);
    endtask

    initial begin
        ldv[0] = '{32'h0000_0000, 8'h00, 8'hFF};
        ldv[1] = '{32'h7654_3210, 8'h01, 8'hFF};
        ldv[2] = '{32'h89AB_CDEF, 8'h80, 8'hA5};
        ldv[3] = '{32'h1111_1111, 8'hFF, 8'h00};
        for (int i = 0; i < 8; i++) begin
            tbl[0][i] = {num_s0[i], sel_of[i], edp[0][i], eblnk[0][i]};
            tbl[1][i] = {num_s1[i], sel_of[i], edp[1][i], eblnk[1][i]};
            tbl[2][i] = {num_s2[i], sel_of[i], edp[2][i], eblnk[2][i]};
            tbl[3][i] = {num_s3[i], sel_of[i], edp[3][i], eblnk[3][i]};
        end

        withdraw();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        n = 0;

        // Idle scan from reset: sel walks all digits, blank stays low.
        run(40);

        // Mid-frame load: old contents until the wrap to digit 0.
        offer(1);
        cycle();
        withdraw();
        run(70);

        // Second valid held while pending; accepted on the first ready cycle.
        offer(2);
        cycle();
        offer(3);
        guard = 0;
        while (!(pend && pend_scn == 3) && guard < 100) begin
            cycle();
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 32'd1, 32'd0);
        withdraw();
        run(40);

        // Accept on a frame-boundary cycle: commit one full frame later.
        while (n % 32 != 31) cycle();
        offer(1);
        cycle();
        withdraw();
        run(70);

        // Async reset mid-digit with a load pending.
        while (n % 32 != 5) cycle();
        offer(2);
        cycle();
        withdraw();
        while (n % 4 != 1) cycle();
        chk("pending_before_reset", {31'd0, ld.load_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        n        = 0;
        shown    = 0;
        pend     = 1'b0;
        pend_scn = 0;
        run(64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
